// File: rtl/lzc_seq.sv
// ============================================================================
// Module   : lzc_seq
// Brief    : Multi-cycle leading-zero counter, scans one CHUNK-bit slice per
//            clock MSB-first through a single shared slice encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lzc_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_zero
);

    localparam int c_NSLICE = WIDTH / CHUNK;
    localparam int c_IW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam int c_LZW    = $clog2(CHUNK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_sr;
    logic [CW-1:0]     r_acc;
    logic [c_IW-1:0]   r_idx;
    logic              r_zero;

    logic [CHUNK-1:0]  w_slice;
    logic [c_LZW-1:0]  w_lz;
    logic              w_nonzero;
    logic              w_last;
    logic              w_accept;

    assign w_slice   = r_sr[WIDTH-1 -: CHUNK];
    assign w_nonzero = |w_slice;
    assign w_last    = (r_idx == c_IW'(c_NSLICE - 1));
    assign w_accept  = (r_state == S_IDLE) && in_valid && !clear;

    // Ascending scan so the highest set bit is the final assignment to win.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (w_slice[i]) begin
                w_lz = c_LZW'(CHUNK - 1 - i);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_SCAN;
            S_SCAN:  if (w_nonzero || w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clear) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sr  <= in_data;
                r_acc <= '0;
                r_idx <= '0;
            end else if (!clear && r_state == S_SCAN) begin
                if (w_nonzero) begin
                    r_acc  <= r_acc + CW'(w_lz);
                    r_zero <= 1'b0;
                end else if (w_last) begin
                    r_acc  <= CW'(WIDTH);
                    r_zero <= 1'b1;
                end else begin
                    r_acc <= r_acc + CW'(CHUNK);
                    r_sr  <= r_sr << CHUNK;
                    r_idx <= r_idx + c_IW'(1);
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_count = r_acc;
    assign out_zero  = r_zero;

endmodule

`default_nettype wire
